// File: rtl/tap_delay_buffer.sv
// rtl/tap_delay_buffer.sv - run-time programmable tap delay line with valid/ready handshakes
module tap_delay_buffer #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 64,
  parameter int DEFAULT_TAP = 20,
  localparam int TW         = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    cfg_we,
  input  logic [TW-1:0]           cfg_tap,
  input  logic                    flush,
  output logic [TW-1:0]           fill_level
);

  logic signed [WIDTH-1:0] line [DEPTH];
  logic [TW-1:0]           tap;
  logic [TW-1:0]           tap_clamped;
  logic signed [WIDTH-1:0] tap_word;
  logic                    accept;

  // Stall whenever config/flush owns the cycle or the output register is still occupied
  always_comb begin
    in_ready = !cfg_we && !flush && (!out_valid || out_ready);
    accept   = in_valid && in_ready;
  end

  // Out-of-range tap requests saturate at the full line depth
  always_comb begin
    tap_clamped = (cfg_tap > TW'(DEPTH)) ? TW'(DEPTH) : cfg_tap;
  end

  // Select the pre-shift sample that sits tap positions behind the incoming one
  always_comb begin
    tap_word = in_data;
    for (int i = 0; i < DEPTH; i++) begin
      if (tap == TW'(i + 1)) tap_word = line[i];
    end
  end

  // Delay line storage: shifts only on an accepted sample, kept across flush and retap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) line[i] <= '0;
    end else if (accept) begin
      line[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) line[i] <= line[i-1];
    end
  end

  // Tap register, fill tracking and output register; flush outranks config outranks accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap        <= TW'(DEFAULT_TAP);
      fill_level <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else if (flush) begin
      if (cfg_we) tap <= tap_clamped;
      fill_level <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else if (cfg_we) begin
      tap        <= tap_clamped;
      fill_level <= '0;
      out_valid  <= 1'b0;
    end else if (accept) begin
      if (fill_level != TW'(DEPTH)) fill_level <= fill_level + 1'b1;
      out_data  <= tap_word;
      out_valid <= (fill_level >= tap);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tap_delay_buffer.sv
// tb/tb_tap_delay_buffer.sv - self-checking bench for tap_delay_buffer
module tb_tap_delay_buffer;

  localparam int WIDTH = 32;
  localparam int DEPTH = 64;
  localparam int DTAP  = 20;
  localparam int TW    = $clog2(DEPTH + 1);

  logic                    clk;
  logic                    rst;
  logic signed [WIDTH-1:0] in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    cfg_we;
  logic [TW-1:0]           cfg_tap;
  logic                    flush;
  logic [TW-1:0]           fill_level;

  tap_delay_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DEFAULT_TAP(DTAP)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .cfg_we(cfg_we), .cfg_tap(cfg_tap), .flush(flush), .fill_level(fill_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: history of every accepted sample, count since last clear, current tap
  logic [31:0] hist [$];
  int          m_cnt;
  int          m_tap;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_known;

  function automatic int clamp_tap(input int t);
    return (t > DEPTH) ? DEPTH : t;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_tap = DTAP; m_valid = 1'b0; m_data = '0; m_known = 1'b1;
  endtask

  // One clock: drive inputs, check combinational ready, step the model, check registered outputs
  task automatic cycle(input logic vin, input logic [31:0] din, input logic ordy,
                       input logic we, input int tp, input logic fl);
    logic rdy, acc;
    in_valid = vin; in_data = din; out_ready = ordy;
    cfg_we = we; cfg_tap = TW'(tp); flush = fl;
    #1;
    rdy = !we && !fl && (!m_valid || ordy);
    acc = vin && rdy;
    chk("in_ready", 32'(in_ready), 32'(rdy));
    if (fl) begin
      m_cnt = 0; m_valid = 1'b0; m_data = '0; m_known = 1'b1;
      if (we) m_tap = clamp_tap(tp);
    end else if (we) begin
      m_tap = clamp_tap(tp); m_cnt = 0; m_valid = 1'b0;
    end else if (acc) begin
      hist.push_back(din);
      m_valid = (m_cnt >= m_tap);
      if (m_valid) begin
        m_data = hist[hist.size() - 1 - m_tap];
        m_known = 1'b1;
      end else begin
        m_known = 1'b0;
      end
      m_cnt++;
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("fill_level", 32'(fill_level), 32'((m_cnt > DEPTH) ? DEPTH : m_cnt));
    if (m_known) chk("out_data", 32'(out_data), m_data);
  endtask

  // Asynchronous reset pulse between clock edges; state must clear before any edge
  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0; cfg_we = 1'b0; flush = 1'b0; out_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_fill", 32'(fill_level), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic        vin;
    logic [31:0] din;
    logic        ordy;
    logic        we;
    int          tp;
    logic        fl;
    logic        e_rdy;
    logic        e_valid;
    logic [31:0] e_data;
    int          e_fill;
  } vec_t;

  vec_t vecs [13];

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    logic [31:0] first_data;

    // vin din ordy we tap fl | rdy valid data fill
    vecs[0]  = '{1, 99, 1, 1,  0, 0, 0, 0, 0,  0};
    vecs[1]  = '{1,  5, 1, 0,  0, 0, 1, 1, 5,  1};
    vecs[2]  = '{1,  6, 1, 0,  0, 0, 1, 1, 6,  2};
    vecs[3]  = '{1,  7, 1, 0,  0, 0, 1, 1, 7,  3};
    vecs[4]  = '{0,  0, 1, 0,  0, 0, 1, 0, 7,  3};
    vecs[5]  = '{1,  8, 0, 0,  0, 0, 1, 1, 8,  4};
    vecs[6]  = '{1,  9, 0, 0,  0, 0, 0, 1, 8,  4};
    vecs[7]  = '{1,  9, 0, 0,  0, 1, 0, 0, 0,  0};
    vecs[8]  = '{0,  0, 1, 1, 74, 0, 0, 0, 0,  0};
    vecs[9]  = '{0,  0, 1, 1,  2, 0, 0, 0, 0,  0};
    vecs[10] = '{1, 10, 1, 0,  0, 0, 1, 0, 7,  1};
    vecs[11] = '{1, 11, 1, 0,  0, 0, 1, 0, 8,  2};
    vecs[12] = '{1, 12, 1, 0,  0, 0, 1, 1, 10, 3};

    rst = 1'b1; in_valid = 0; in_data = '0; out_ready = 0; cfg_we = 0; cfg_tap = '0; flush = 0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_fill", 32'(fill_level), 32'd0);
    chk("reset_data", 32'(out_data), 32'd0);
    chk("reset_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    // Table: tap 0 passthrough, stall, flush, clamp, retap with stale line contents
    for (int i = 0; i < 13; i++) begin
      in_valid = vecs[i].vin; in_data = vecs[i].din; out_ready = vecs[i].ordy;
      cfg_we = vecs[i].we; cfg_tap = TW'(vecs[i].tp); flush = vecs[i].fl;
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d_data", i), 32'(out_data), vecs[i].e_data);
      chk($sformatf("vec%0d_fill", i), 32'(fill_level), 32'(vecs[i].e_fill));
    end

    // Default tap priming: first output one clock after sample 20, carrying sample 0
    do_reset();
    first = -1; first_data = '0;
    for (int k = 0; k < 40; k++) begin
      cycle(1, 32'(k), 1, 0, 0, 0);
      if (first < 0 && out_valid) begin first = k; first_data = out_data; end
    end
    chk("t1_first_idx", 32'(first), 32'd20);
    chk("t1_first_data", first_data, 32'd0);

    // Clamped tap: request 74, primes at sample 64, fill saturates
    cycle(0, 0, 1, 1, DEPTH + 10, 0);
    first = -1;
    for (int k = 0; k <= 70; k++) begin
      cycle(1, 32'(k), 1, 0, 0, 0);
      if (first < 0 && out_valid) begin first = k; first_data = out_data; end
    end
    chk("t3_first_idx", 32'(first), 32'd64);
    chk("t3_first_data", first_data, 32'd0);
    chk("t3_fill_sat", 32'(fill_level), 32'(DEPTH));

    // Backpressure: primed short tap, downstream stalls 5 clocks, then resumes
    cycle(0, 0, 1, 1, 3, 0);
    for (int k = 0; k < 10; k++) cycle(1, 32'(100 + k), 1, 0, 0, 0);
    for (int k = 0; k < 5; k++) cycle(1, 32'(200 + k), 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) cycle(1, 32'(300 + k), 1, 0, 0, 0);

    // Flush while primed with input pending, then re-prime
    cycle(1, 32'(400), 1, 0, 0, 1);
    for (int k = 0; k < 8; k++) cycle(1, 32'(500 + k), 1, 0, 0, 0);
    cycle(1, 32'(600), 1, 1, 5, 1);
    for (int k = 0; k < 8; k++) cycle(1, 32'(700 + k), 1, 0, 0, 0);

    // Mid-stream reset: tap returns to the default
    do_reset();
    first = -1;
    for (int k = 0; k < 25; k++) begin
      cycle(1, 32'(800 + k), 1, 0, 0, 0);
      if (first < 0 && out_valid) begin first = k; first_data = out_data; end
    end
    chk("t6_first_idx", 32'(first), 32'd20);
    chk("t6_first_data", first_data, 32'd800);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int r;
      int tp;
      r = int'($urandom_range(0, 199));
      if (r == 199 && (i % 5) == 0) begin
        do_reset();
      end else begin
        tp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(56, 80)) : int'($urandom_range(0, 6));
        cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
              r < 4, tp, r >= 4 && r < 7);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
